calc_seq_ctrl: RTL
==================

Name: calc_seq_ctrl

Overview:
Sequencer for the calc path. It drives the shared step counter `cnt` that the MAC/dot-product stages and the result-capture/compress register stage decode. It runs one 70-step pass per tile over a configurable number of tiles. After each pass it presents the compressed 8-bit result on a valid/ready output and waits for acceptance before starting the next tile.

Parameters:
CNT_W, 7, width of step counter output
CAP_CNT, 68, step at which downstream captures the three dot-product partials
CMP_CNT, 69, last step; downstream loads compressed byte on the edge where cnt==CMP_CNT
TILE_W, 4, width of tile-count configuration and tile index

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  request to begin a frame; accepted only when start_ready=1
num_tiles  input  TILE_W  tiles in frame; sampled on start acceptance; 0 treated as 1
start_ready  output  1  high only in IDLE
stall  input  1  freezes step counter while in RUN
cnt  output  CNT_W  step counter to datapath
acc_clr  output  1  one-cycle pulse: clear MAC accumulators before a pass
capture_en  output  1  high when state==RUN && cnt==CAP_CNT && !stall
ans_in  input  8  compressed result byte from capture/compress stage (ans_reg)
out_valid  output  1  result byte available
out_ready  input  1  consumer accepts result
out_data  output  8  result byte
out_tile  output  TILE_W  tile index of out_data
busy  output  1  state != IDLE
frame_done  output  1  one-cycle pulse when last tile's result is accepted

Behaviour:
- Synchronous reset. All registers are updated only on posedge clk.
- rst=1 forces:
  - state=IDLE, cnt=0, tile_idx=0, tiles_lat=0;
  - all outputs low/zero, except start_ready=1 in the cycle after reset.
- Mid-operation reset aborts immediately; there is no drain.
- States: IDLE, RUN, WAIT_OUT.
- IDLE:
  - cnt=0, start_ready=1.
  - start=1 → RUN next cycle, with: cnt=0, tile_idx=0, tiles_lat=(num_tiles==0 ? 1 : num_tiles), acc_clr=1 in the first RUN cycle.
- RUN:
  - stall=0: cnt increments by 1 per cycle. stall=1: cnt holds.
  - When cnt==CMP_CNT and stall=0: next state WAIT_OUT, cnt returns to 0. The datapath loads ans_reg on that edge.
  - cnt never exceeds CMP_CNT and never wraps through CNT_W.
  - Pass latency from acc_clr to out_valid: CMP_CNT+2 = 71 cycles with no stalls, plus 1 cycle per stalled RUN cycle.
- WAIT_OUT:
  - Registered outputs: out_valid=1, out_data=ans_in, out_tile=tile_idx.
  - out_data stays stable while out_valid=1 && out_ready=0.
  - On out_valid && out_ready:
    - If tile_idx==tiles_lat-1: → IDLE, frame_done=1 for one cycle, out_valid drops next cycle.
    - Otherwise: tile_idx+1, → RUN, cnt=0, acc_clr=1 in the first RUN cycle, out_valid drops.
  - No back-to-back output across tiles: at least 71 cycles between consecutive results.
- start outside IDLE is ignored; it is neither queued nor an error. stall outside RUN is ignored.
- acc_clr and frame_done are never asserted in the same cycle.
- Simultaneous out_ready and start while in WAIT_OUT of the last tile: the result is accepted and start is ignored. A new frame can be accepted the next cycle (IDLE).

Test Plan:
1. Reset then start=1, num_tiles=1, no stall, out_ready=1, ans_in=0x5A:
   - acc_clr one cycle after start.
   - cnt 0..69 over 70 cycles; capture_en only at cnt=68.
   - out_valid with out_data=0x5A, out_tile=0, 71 cycles after acc_clr.
   - frame_done coincident with acceptance; busy low next cycle.
2. num_tiles=3, out_ready=1:
   - Three results with out_tile 0,1,2.
   - acc_clr pulses three times.
   - frame_done only after tile 2.
3. stall=1 for 5 cycles at cnt=30, then at cnt=68:
   - cnt holds each time.
   - capture_en stays low during the stall at cnt=68 and asserts once the stall releases.
   - out_valid arrives 10 cycles later than scenario 1.
4. Backpressure: out_ready=0 for 20 cycles:
   - out_valid and out_data stay stable, cnt=0.
   - out_ready=1 → single acceptance; next tile starts.
5. num_tiles=0 → exactly one tile processed. start pulsed during RUN → ignored; start_ready=0 throughout.
6. rst=1 asserted at cnt=40 of tile 1:
   - Next cycle: state IDLE, cnt=0, out_valid=0, busy=0, start_ready=1.
   - A fresh frame runs normally afterwards.

Source files
------------

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: steps the calc datapath through one 70-step pass per tile and hands each result byte out over valid/ready
module calc_seq_ctrl #(
    parameter int CNT_W   = 7,
    parameter int CAP_CNT = 68,
    parameter int CMP_CNT = 69,
    parameter int TILE_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TILE_W-1:0] num_tiles,
    output logic              start_ready,
    input  logic              stall,
    output logic [CNT_W-1:0]  cnt,
    output logic              acc_clr,
    output logic              capture_en,
    input  logic [7:0]        ans_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [TILE_W-1:0] out_tile,
    output logic              busy,
    output logic              frame_done
);
    typedef enum logic [1:0] {IDLE, RUN, WAIT_OUT} state_t;
    localparam logic [CNT_W-1:0] cap_val = CNT_W'(CAP_CNT);
    localparam logic [CNT_W-1:0] cmp_val = CNT_W'(CMP_CNT);
    state_t state;
    logic [TILE_W-1:0] tile_idx, tiles_lat;
    logic accept, last;
    assign accept      = state == WAIT_OUT && out_valid && out_ready;
    assign last        = tile_idx == tiles_lat - 1'b1;
    assign start_ready = state == IDLE;
    assign busy        = state != IDLE;
    assign capture_en  = state == RUN && cnt == cap_val && !stall;
    assign frame_done  = accept && last;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            tile_idx  <= '0;
            tiles_lat <= '0;
            acc_clr   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tile  <= '0;
        end else begin
            acc_clr <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state     <= RUN;
                    cnt       <= '0;
                    tile_idx  <= '0;
                    tiles_lat <= num_tiles == '0 ? TILE_W'(1) : num_tiles;
                    acc_clr   <= 1'b1;
                end
                RUN: if (!stall) begin
                    state <= cnt == cmp_val ? WAIT_OUT : RUN;
                    cnt   <= cnt == cmp_val ? '0 : cnt + 1'b1;
                end
                WAIT_OUT: if (!out_valid) begin
                    // ans_in was loaded by the datapath on the last RUN edge; latch it once
                    out_valid <= 1'b1;
                    out_data  <= ans_in;
                    out_tile  <= tile_idx;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= last ? IDLE : RUN;
                    tile_idx  <= last ? tile_idx : tile_idx + 1'b1;
                    acc_clr   <= !last;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
